// File: rtl/gpo_pkg.sv
// Shared definitions for the general-purpose output core: register map,
// pulse length width, pulse FSM states and STATUS bit positions.
package gpo_pkg;

   // Register index width on the slot bus
   localparam int ADDR_W = 5;

   // Register map
   localparam logic [ADDR_W-1:0] ADDR_DATA      = 5'd0;
   localparam logic [ADDR_W-1:0] ADDR_SET       = 5'd1;
   localparam logic [ADDR_W-1:0] ADDR_CLR       = 5'd2;
   localparam logic [ADDR_W-1:0] ADDR_TGL       = 5'd3;
   localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 5'd4;
   localparam logic [ADDR_W-1:0] ADDR_PULSE     = 5'd5;
   localparam logic [ADDR_W-1:0] ADDR_STATUS    = 5'd6;
   localparam logic [ADDR_W-1:0] ADDR_PIN       = 5'd7;

   // Pulse length register and down-counter width
   localparam int PULSE_LEN_W = 16;

   // STATUS register bit positions
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_ERR_BIT  = 1;

   // One-shot pulse engine states
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/gpo_pulse_timer.sv
// One-shot pulse engine: latches an inversion mask and holds busy for
// exactly `len` clock periods, counting down to 1. A start while busy is
// rejected (no restart, mask kept) and flagged on `reject` for the owner's
// sticky error bit. A zero length latches the mask but never goes busy.
module gpo_pulse_timer
   import gpo_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PULSE_LEN_W-1:0] len,
   input  logic [W-1:0]           mask_in,
   output logic                   busy,
   output logic [W-1:0]           mask,
   output logic                   reject,
   output state_t                 state
);

   logic [PULSE_LEN_W-1:0] cnt;

   // Pulse FSM with its down-counter and mask latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // The mask is latched even for a zero length so that a
                  // readback shows the last requested pattern.
                  mask <= mask_in;
                  if (len != '0) begin
                     cnt   <= len;
                     state <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               // Counting down to 1 (not 0) gives exactly `len` busy
               // periods and can never wrap, even for len = 65535.
               cnt <= cnt - 1'b1;
               if (cnt == PULSE_LEN_W'(1)) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy   = (state == ACTIVE);
   assign reject = start && (state == ACTIVE);

endmodule

// File: rtl/gpo.sv
// General-purpose output core for one I/O slot. Drives W output pins from
// a CPU-writable register with atomic set/clear/toggle, plus a one-shot
// pulse overlay that inverts selected pins for a programmed cycle count.
//
// Bus handshake: there is no ready/wait signal. A write is accepted on
// every rising edge where cs && write, and takes effect at that edge.
// Reads are side-effect-free; rd_data is a combinational function of addr
// and current register state, so it is valid in the same cycle (zero wait
// states) independent of cs and read.
module gpo
   import gpo_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cs,
   input  logic                 read,
   input  logic                 write,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [31:0]          wr_data,
   output logic [31:0]          rd_data,
   output logic [W-1:0]         data_out
);

   logic                   we;
   logic [W-1:0]           out_reg;
   logic [PULSE_LEN_W-1:0] pulse_len;
   logic                   err;
   logic                   pulse_start;
   logic                   pulse_busy;
   logic [W-1:0]           pulse_mask;
   logic                   pulse_reject;
   state_t                 pulse_state;
   logic                   unused_bits;

   assign we          = cs && write;
   assign pulse_start = we && (addr == ADDR_PULSE);

   // Upper write-data bits beyond W, and the read strobe, carry no meaning
   // for this core.
   assign unused_bits = ^{wr_data, read};

   gpo_pulse_timer #(
      .W (W)
   ) u_pulse_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (pulse_start),
      .len     (pulse_len),
      .mask_in (wr_data[W-1:0]),
      .busy    (pulse_busy),
      .mask    (pulse_mask),
      .reject  (pulse_reject),
      .state   (pulse_state)
   );

   // Output register with load / atomic set / clear / toggle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_reg <= '0;
      end else if (we) begin
         case (addr)
            ADDR_DATA: out_reg <= wr_data[W-1:0];
            ADDR_SET:  out_reg <= out_reg | wr_data[W-1:0];
            ADDR_CLR:  out_reg <= out_reg & ~wr_data[W-1:0];
            ADDR_TGL:  out_reg <= out_reg ^ wr_data[W-1:0];
            default:   out_reg <= out_reg;
         endcase
      end
   end

   // Pulse length register; a change does not affect a running pulse
   // because the timer copied the length into its own counter at start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pulse_len <= '0;
      end else if (we && (addr == ADDR_PULSE_LEN)) begin
         pulse_len <= wr_data[PULSE_LEN_W-1:0];
      end
   end

   // Sticky error: set by a rejected pulse start, cleared by any STATUS
   // write. Both cannot happen in the same cycle (one address per cycle).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (we && (addr == ADDR_STATUS)) begin
         err <= 1'b0;
      end else if (pulse_reject) begin
         err <= 1'b1;
      end
   end

   // Pins: the pulse is an XOR overlay and never modifies out_reg
   assign data_out = out_reg ^ (pulse_busy ? pulse_mask : '0);

   // Read mux, zero-extended to the bus width
   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_DATA:      rd_data = 32'(out_reg);
         ADDR_PULSE_LEN: rd_data = 32'(pulse_len);
         ADDR_PULSE:     rd_data = 32'(pulse_mask);
         ADDR_STATUS: begin
            rd_data[STATUS_BUSY_BIT] = (pulse_state == ACTIVE);
            rd_data[STATUS_ERR_BIT]  = err;
         end
         ADDR_PIN:       rd_data = 32'(data_out);
         default:        rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_gpo.sv
// Bench for the gpo core: reset readback, a table of hand-computed
// vectors, hand sequences for reset-mid-pulse and the maximum pulse, and
// randomized traffic against a cycle-count based reference model.
module tb_gpo;

   localparam int W = 8;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [W-1:0] data_out;

   int n_checks;
   int n_pass;

   // Reference model: pulse expressed as "busy while edge_n < busy_until"
   logic [W-1:0] m_out;
   logic [W-1:0] m_mask;
   logic [15:0]  m_len;
   bit           m_err;
   int           edge_n;
   int           busy_until;

   typedef struct {
      bit          we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [4:0]  rd_addr;
      logic [31:0] exp_rd;
      logic [W-1:0] exp_pins;
   } vec_t;

   vec_t vt[22];

   gpo #(
      .W (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cs       (cs),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .data_out (data_out)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One bus cycle: drive, take the rising edge, sample 1ns later
   task automatic bus_cycle(input bit we, input logic [4:0] a, input logic [31:0] d);
      cs      = we;
      write   = we;
      addr    = a;
      wr_data = d;
      @(posedge clk);
      #1;
      cs    = 1'b0;
      write = 1'b0;
   endtask

   task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string name);
      read = 1'b1;
      addr = a;
      #1;
      chk(name, rd_data, exp);
      read = 1'b0;
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Model helpers
   function automatic bit m_busy();
      return edge_n < busy_until;
   endfunction

   function automatic logic [W-1:0] m_pins();
      return m_out ^ (m_busy() ? m_mask : '0);
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         5'd0: r = 32'(m_out);
         5'd4: r = 32'(m_len);
         5'd5: r = 32'(m_mask);
         5'd6: r = {30'd0, m_err, m_busy()};
         5'd7: r = 32'(m_pins());
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic m_reset();
      m_out = '0;
      m_mask = '0;
      m_len = '0;
      m_err = 1'b0;
      edge_n = 0;
      busy_until = 0;
   endtask

   // Advance the model by one edge carrying an optional write
   task automatic m_edge(input bit we, input logic [4:0] a, input logic [31:0] d);
      bit was_busy;
      was_busy = m_busy();
      edge_n++;
      if (we) begin
         case (a)
            5'd0: m_out = d[W-1:0];
            5'd1: m_out = m_out | d[W-1:0];
            5'd2: m_out = m_out & ~d[W-1:0];
            5'd3: m_out = m_out ^ d[W-1:0];
            5'd4: m_len = d[15:0];
            5'd5: begin
               if (was_busy) begin
                  m_err = 1'b1;
               end else begin
                  m_mask = d[W-1:0];
                  if (m_len != 0) busy_until = edge_n + int'(m_len);
               end
            end
            5'd6: m_err = 1'b0;
            default: ;
         endcase
      end
   endtask

   initial begin
      int cnt;
      n_checks = 0;
      n_pass   = 0;
      cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;

      // Reset state: every address reads 0, pins 0
      do_reset();
      chk("reset_pins", 32'(data_out), 32'h0);
      for (int i = 0; i < 32; i++) begin
         rd_check(5'(i), 32'h0, $sformatf("reset_rd_addr%0d", i));
      end
      align();

      // Vectors: {we, addr, data, rd_addr, exp_rd, exp_pins}
      vt[0]  = '{1'b1, 5'd0,  32'hA5,        5'd0, 32'hA5, 8'hA5};
      vt[1]  = '{1'b1, 5'd1,  32'h0A,        5'd1, 32'h00, 8'hAF};
      vt[2]  = '{1'b1, 5'd2,  32'h81,        5'd0, 32'h2E, 8'h2E};
      vt[3]  = '{1'b1, 5'd3,  32'hFF,        5'd0, 32'hD1, 8'hD1};
      vt[4]  = '{1'b1, 5'd4,  32'h0001_0003, 5'd4, 32'h03, 8'hD1};
      vt[5]  = '{1'b1, 5'd8,  32'hFF,        5'd8, 32'h00, 8'hD1};
      vt[6]  = '{1'b1, 5'd31, 32'h00,        5'd0, 32'hD1, 8'hD1};
      vt[7]  = '{1'b1, 5'd4,  32'h00,        5'd4, 32'h00, 8'hD1};
      vt[8]  = '{1'b1, 5'd5,  32'hFF,        5'd6, 32'h00, 8'hD1};
      vt[9]  = '{1'b0, 5'd0,  32'h00,        5'd5, 32'hFF, 8'hD1};
      vt[10] = '{1'b1, 5'd0,  32'h00,        5'd7, 32'h00, 8'h00};
      vt[11] = '{1'b1, 5'd4,  32'h05,        5'd4, 32'h05, 8'h00};
      vt[12] = '{1'b1, 5'd5,  32'h03,        5'd6, 32'h01, 8'h03};
      vt[13] = '{1'b0, 5'd0,  32'h00,        5'd6, 32'h01, 8'h03};
      vt[14] = '{1'b1, 5'd1,  32'h01,        5'd7, 32'h02, 8'h02};
      vt[15] = '{1'b1, 5'd5,  32'hF0,        5'd6, 32'h03, 8'h02};
      vt[16] = '{1'b0, 5'd0,  32'h00,        5'd0, 32'h01, 8'h02};
      vt[17] = '{1'b0, 5'd0,  32'h00,        5'd6, 32'h02, 8'h01};
      vt[18] = '{1'b1, 5'd6,  32'h00,        5'd6, 32'h00, 8'h01};
      vt[19] = '{1'b0, 5'd0,  32'h00,        5'd5, 32'h03, 8'h01};
      vt[20] = '{1'b0, 5'd0,  32'h00,        5'd2, 32'h00, 8'h01};
      vt[21] = '{1'b0, 5'd0,  32'h00,        5'd3, 32'h00, 8'h01};

      for (int i = 0; i < 22; i++) begin
         bus_cycle(vt[i].we, vt[i].addr, vt[i].data);
         chk($sformatf("vec%0d_pins", i), 32'(data_out), 32'(vt[i].exp_pins));
         rd_check(vt[i].rd_addr, vt[i].exp_rd, $sformatf("vec%0d_rd", i));
      end

      // Reset in the middle of a pulse clears pins without a clock edge
      bus_cycle(1'b1, 5'd4, 32'd100);
      bus_cycle(1'b1, 5'd5, 32'h0F);
      chk("midpulse_pins_before", 32'(data_out), 32'h0E);
      bus_cycle(1'b0, 5'd0, 32'h0);
      bus_cycle(1'b0, 5'd0, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_pins", 32'(data_out), 32'h0);
      rd_check(5'd6, 32'h0, "async_reset_status");
      rd_check(5'd0, 32'h0, "async_reset_data");
      rd_check(5'd4, 32'h0, "async_reset_len");
      align();
      reset = 1'b1;

      // Maximum length pulse: busy for exactly 65535 sampled cycles
      bus_cycle(1'b1, 5'd4, 32'hFFFF);
      bus_cycle(1'b1, 5'd5, 32'h01);
      cnt = 0;
      while (data_out == 8'h01 && cnt < 70000) begin
         cnt++;
         bus_cycle(1'b0, 5'd0, 32'h0);
      end
      chk("long_pulse_cycles", 32'(cnt), 32'd65535);
      rd_check(5'd6, 32'h0, "long_pulse_status_after");

      // Randomized traffic against the model
      align();
      do_reset();
      m_reset();
      for (int i = 0; i < 1500; i++) begin
         bit          we;
         int unsigned sel;
         logic [4:0]  a;
         logic [31:0] d;
         we  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 11);
         a   = (sel <= 8) ? 5'(sel) : 5'($urandom_range(9, 31));
         d   = $urandom();
         if (a == 5'd4) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 10));
         bus_cycle(we, a, d);
         m_edge(we, a, d);
         chk($sformatf("rand%0d_pins", i), 32'(data_out), 32'(m_pins()));
         a = 5'($urandom_range(0, 31));
         rd_check(a, m_rd(a), $sformatf("rand%0d_rd%0d", i, a));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
